// File: rtl/snake_move_unit.sv
// Snake motion and collision engine: timed body shifting, sticky wall/self hit flags, registered cell query.
// Optional build macro SNAKE_WRAP_EN makes the grid edges wrap around instead of acting as walls.
module snake_move_unit #(
    parameter int unsigned GRID_W    = 40,
    parameter int unsigned GRID_H    = 30,
    parameter int unsigned MAX_LEN   = 16,
    parameter int unsigned STEP_SLOW = 25000000,
    parameter int unsigned STEP_MID  = 12500000,
    parameter int unsigned STEP_FAST = 6250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key0_right,
    input  logic       key1_left,
    input  logic       key2_down,
    input  logic       key3_up,
    input  logic       start_signal,
    input  logic       clear_signal,
    input  logic [1:0] fact_status,
    input  logic       eat_pulse,
    input  logic [5:0] q_x,
    input  logic [4:0] q_y,
    output logic [5:0] head_x,
    output logic [4:0] head_y,
    output logic [4:0] snake_len,
    output logic       move_tick,
    output logic       hit_wall,
    output logic       hit_body,
    output logic       q_head,
    output logic       q_body
);

    localparam int unsigned XW       = 6;
    localparam int unsigned YW       = 5;
    localparam int unsigned XE       = XW + 1;
    localparam int unsigned YE       = YW + 1;
    localparam int unsigned LW       = 5;
    localparam int unsigned STEP_MS  = (STEP_SLOW > STEP_MID) ? STEP_SLOW : STEP_MID;
    localparam int unsigned STEP_MAX = (STEP_MS > STEP_FAST) ? STEP_MS : STEP_FAST;
    localparam int unsigned CNT_W    = $clog2(STEP_MAX + 1);

    localparam logic [XW-1:0] INIT_X    = XW'(GRID_W / 2);
    localparam logic [YW-1:0] INIT_Y    = YW'(GRID_H / 2);
    localparam logic [LW-1:0] INIT_LEN  = LW'(3);
    localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);
    localparam logic [XE-1:0] X_LAST    = XE'(GRID_W - 1);
    localparam logic [YE-1:0] Y_LAST    = YE'(GRID_H - 1);

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_UP    = 2'd3
    } dir_t;

    function automatic dir_t reverse_of(input dir_t d);
        case (d)
            DIR_RIGHT: reverse_of = DIR_LEFT;
            DIR_LEFT:  reverse_of = DIR_RIGHT;
            DIR_DOWN:  reverse_of = DIR_UP;
            default:   reverse_of = DIR_DOWN;
        endcase
    endfunction

    logic [XW-1:0]    seg_x_q [MAX_LEN];
    logic [XW-1:0]    seg_x_d [MAX_LEN];
    logic [YW-1:0]    seg_y_q [MAX_LEN];
    logic [YW-1:0]    seg_y_d [MAX_LEN];
    logic [LW-1:0]    len_q, len_d;
    dir_t             dir_q, dir_d;
    dir_t             pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             grow_q, grow_d;
    logic             hit_wall_q, hit_wall_d;
    logic             hit_body_q, hit_body_d;
    logic             tick_q, tick_d;
    logic             q_head_q, q_head_d;
    logic             q_body_q, q_body_d;

    logic [CNT_W-1:0] period_m1;
    logic             running;
    logic             step;
    logic             key_vld;
    dir_t             key_dir;
    dir_t             dir_eff;
    logic             grow_eff;
    logic [XE-1:0]    nx_ext;
    logic [YE-1:0]    ny_ext;
    logic [XW-1:0]    next_x;
    logic [YW-1:0]    next_y;
    logic             wall_c;
    logic             body_c;

    // Step period is re-selected every cycle so a speed change takes effect mid-count.
    always_comb begin
        case (fact_status)
            2'b01:   period_m1 = CNT_W'(STEP_MID - 1);
            2'b10:   period_m1 = CNT_W'(STEP_FAST - 1);
            default: period_m1 = CNT_W'(STEP_SLOW - 1);
        endcase
    end

    assign running  = start_signal && !hit_wall_q && !hit_body_q;
    assign step     = running && (cnt_q >= period_m1);
    assign grow_eff = grow_q || eat_pulse;

    // Highest-priority pressed key is taken alone; a reversal is dropped rather than falling through.
    always_comb begin
        key_vld = 1'b1;
        key_dir = DIR_RIGHT;
        if (!key3_up) begin
            key_dir = DIR_UP;
        end else if (!key2_down) begin
            key_dir = DIR_DOWN;
        end else if (!key1_left) begin
            key_dir = DIR_LEFT;
        end else if (!key0_right) begin
            key_dir = DIR_RIGHT;
        end else begin
            key_vld = 1'b0;
        end
        dir_eff = pend_q;
        if (running && key_vld && (key_dir != reverse_of(dir_q))) begin
            dir_eff = key_dir;
        end
    end

    // Candidate head position carries one extra bit so that underflow shows up as a set MSB.
    always_comb begin
        nx_ext = {1'b0, seg_x_q[0]};
        ny_ext = {1'b0, seg_y_q[0]};
        case (dir_eff)
            DIR_RIGHT: nx_ext = {1'b0, seg_x_q[0]} + XE'(1);
            DIR_LEFT:  nx_ext = {1'b0, seg_x_q[0]} - XE'(1);
            DIR_DOWN:  ny_ext = {1'b0, seg_y_q[0]} + YE'(1);
            default:   ny_ext = {1'b0, seg_y_q[0]} - YE'(1);
        endcase
`ifdef SNAKE_WRAP_EN
        wall_c = 1'b0;
        next_x = nx_ext[XE-1] ? XW'(GRID_W - 1) : ((nx_ext > X_LAST) ? '0 : nx_ext[XW-1:0]);
        next_y = ny_ext[YE-1] ? YW'(GRID_H - 1) : ((ny_ext > Y_LAST) ? '0 : ny_ext[YW-1:0]);
`else
        wall_c = nx_ext[XE-1] || (nx_ext > X_LAST) || ny_ext[YE-1] || (ny_ext > Y_LAST);
        next_x = nx_ext[XW-1:0];
        next_y = ny_ext[YW-1:0];
`endif
    end

    // The tail only blocks the move when it will not vacate its cell (growth pending).
    always_comb begin
        body_c = 1'b0;
        for (int i = 1; i < int'(MAX_LEN); i++) begin
            if ((LW'(i) < len_q) && ((LW'(i) != (len_q - LW'(1))) || grow_eff) &&
                (seg_x_q[i] == next_x) && (seg_y_q[i] == next_y)) begin
                body_c = 1'b1;
            end
        end
    end

    always_comb begin
        seg_x_d    = seg_x_q;
        seg_y_d    = seg_y_q;
        len_d      = len_q;
        dir_d      = dir_q;
        pend_d     = pend_q;
        cnt_d      = '0;
        grow_d     = grow_eff;
        hit_wall_d = hit_wall_q;
        hit_body_d = hit_body_q;
        tick_d     = 1'b0;
        q_head_d   = (seg_x_q[0] == q_x) && (seg_y_q[0] == q_y);
        q_body_d   = 1'b0;
        for (int i = 1; i < int'(MAX_LEN); i++) begin
            if ((LW'(i) < len_q) && (seg_x_q[i] == q_x) && (seg_y_q[i] == q_y)) begin
                q_body_d = 1'b1;
            end
        end

        if (running) begin
            cnt_d  = cnt_q + CNT_W'(1);
            pend_d = dir_eff;
        end

        if (step) begin
            cnt_d  = '0;
            dir_d  = dir_eff;
            grow_d = 1'b0;
            tick_d = 1'b1;
            if (wall_c) begin
                hit_wall_d = 1'b1;
            end else if (body_c) begin
                hit_body_d = 1'b1;
            end else begin
                for (int i = 1; i < int'(MAX_LEN); i++) begin
                    seg_x_d[i] = seg_x_q[i-1];
                    seg_y_d[i] = seg_y_q[i-1];
                end
                seg_x_d[0] = next_x;
                seg_y_d[0] = next_y;
                if (grow_eff && (len_q < MAX_LEN_L)) begin
                    len_d = len_q + LW'(1);
                end
            end
        end

        if (clear_signal) begin
            for (int i = 0; i < int'(MAX_LEN); i++) begin
                seg_x_d[i] = '0;
                seg_y_d[i] = '0;
            end
            seg_x_d[0] = INIT_X;
            seg_x_d[1] = INIT_X - XW'(1);
            seg_x_d[2] = INIT_X - XW'(2);
            seg_y_d[0] = INIT_Y;
            seg_y_d[1] = INIT_Y;
            seg_y_d[2] = INIT_Y;
            len_d      = INIT_LEN;
            dir_d      = DIR_RIGHT;
            pend_d     = DIR_RIGHT;
            cnt_d      = '0;
            grow_d     = 1'b0;
            hit_wall_d = 1'b0;
            hit_body_d = 1'b0;
            tick_d     = 1'b0;
            q_head_d   = 1'b0;
            q_body_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(MAX_LEN); i++) begin
                seg_x_q[i] <= '0;
                seg_y_q[i] <= '0;
            end
            seg_x_q[0] <= INIT_X;
            seg_x_q[1] <= INIT_X - XW'(1);
            seg_x_q[2] <= INIT_X - XW'(2);
            seg_y_q[0] <= INIT_Y;
            seg_y_q[1] <= INIT_Y;
            seg_y_q[2] <= INIT_Y;
            len_q      <= INIT_LEN;
            dir_q      <= DIR_RIGHT;
            pend_q     <= DIR_RIGHT;
            cnt_q      <= '0;
            grow_q     <= 1'b0;
            hit_wall_q <= 1'b0;
            hit_body_q <= 1'b0;
            tick_q     <= 1'b0;
            q_head_q   <= 1'b0;
            q_body_q   <= 1'b0;
        end else begin
            seg_x_q    <= seg_x_d;
            seg_y_q    <= seg_y_d;
            len_q      <= len_d;
            dir_q      <= dir_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            grow_q     <= grow_d;
            hit_wall_q <= hit_wall_d;
            hit_body_q <= hit_body_d;
            tick_q     <= tick_d;
            q_head_q   <= q_head_d;
            q_body_q   <= q_body_d;
        end
    end

    assign head_x    = seg_x_q[0];
    assign head_y    = seg_y_q[0];
    assign snake_len = len_q;
    assign move_tick = tick_q;
    assign hit_wall  = hit_wall_q;
    assign hit_body  = hit_body_q;
    assign q_head    = q_head_q;
    assign q_body    = q_body_q;

endmodule

// File: tb/tb_snake_move_unit.sv
// Bench for snake_move_unit: directed vector table plus random play against a queue-based snake model.
module tb_snake_move_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] keys_n;   // {up, down, left, right}, active low
    logic       start_s;
    logic       clr;
    logic [1:0] fs;
    logic       eat;
    logic [5:0] qx;
    logic [4:0] qy;
    logic [5:0] head_x;
    logic [4:0] head_y;
    logic [4:0] snake_len;
    logic       move_tick, hit_wall, hit_body, q_head, q_body;

    always #5 clk = ~clk;

    snake_move_unit #(
        .GRID_W(40), .GRID_H(30), .MAX_LEN(16),
        .STEP_SLOW(8), .STEP_MID(4), .STEP_FAST(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .key0_right(keys_n[0]), .key1_left(keys_n[1]), .key2_down(keys_n[2]), .key3_up(keys_n[3]),
        .start_signal(start_s), .clear_signal(clr), .fact_status(fs), .eat_pulse(eat),
        .q_x(qx), .q_y(qy),
        .head_x(head_x), .head_y(head_y), .snake_len(snake_len), .move_tick(move_tick),
        .hit_wall(hit_wall), .hit_body(hit_body), .q_head(q_head), .q_body(q_body)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference snake: head at queue front, queue length is the segment count.
    int  mx[$];
    int  my[$];
    int  mdir, mpend, mcnt;
    bit  mgrow, mhw, mhb;
    bit  e_tick, e_qh, e_qb;
    int  DXV[4] = '{1, -1, 0, 0};   // right, left, down, up
    int  DYV[4] = '{0, 0, 1, -1};

    task automatic model_init();
        mx = '{20, 19, 18};
        my = '{15, 15, 15};
        mdir = 0; mpend = 0; mcnt = 0;
        mgrow = 0; mhw = 0; mhb = 0;
    endtask

    task automatic model_clock();
        int  k, nx, ny, p, old;
        bit  g, run, hitb;
        e_qh = (mx[0] == int'(qx)) && (my[0] == int'(qy));
        e_qb = 0;
        for (int i = 1; i < mx.size(); i++)
            if (mx[i] == int'(qx) && my[i] == int'(qy)) e_qb = 1;
        e_tick = 0;
        if (!rst_n || clr) begin
            model_init();
            e_qh = 0;
            e_qb = 0;
            return;
        end
        run = start_s && !mhw && !mhb;
        p   = (fs == 2'b01) ? 4 : (fs == 2'b10) ? 2 : 8;
        g   = mgrow || eat;
        if (run) begin
            k = -1;
            if (!keys_n[3]) k = 3;
            else if (!keys_n[2]) k = 2;
            else if (!keys_n[1]) k = 1;
            else if (!keys_n[0]) k = 0;
            if (k >= 0 && !(DXV[k] == -DXV[mdir] && DYV[k] == -DYV[mdir])) mpend = k;
        end
        if (run && mcnt >= p - 1) begin
            mcnt   = 0;
            e_tick = 1;
            mdir   = mpend;
            mgrow  = 0;
            nx = mx[0] + DXV[mdir];
            ny = my[0] + DYV[mdir];
            if (nx < 0 || nx > 39 || ny < 0 || ny > 29) begin
                mhw = 1;
            end else begin
                hitb = 0;
                for (int i = 1; i < mx.size(); i++) begin
                    if (i == mx.size() - 1 && !g) continue;
                    if (mx[i] == nx && my[i] == ny) hitb = 1;
                end
                if (hitb) begin
                    mhb = 1;
                end else begin
                    old = mx.size();
                    mx.push_front(nx);
                    my.push_front(ny);
                    if (!(g && old < 16)) begin
                        void'(mx.pop_back());
                        void'(my.pop_back());
                    end
                end
            end
        end else begin
            mcnt  = run ? mcnt + 1 : 0;
            mgrow = g;
        end
    endtask

    task automatic run_cycle();
        logic [20:0] act, exp;
        model_clock();
        @(posedge clk);
        #1;
        cyc++;
        act = {head_x, head_y, snake_len, move_tick, hit_wall, hit_body, q_head, q_body};
        exp = {6'(mx[0]), 5'(my[0]), 5'(mx.size()), e_tick, mhw, mhb, e_qh, e_qb};
        check("model", 32'(act), 32'(exp));
    endtask

    typedef struct {
        string      name;
        bit         clr;
        bit         start;
        logic [3:0] keys_n;
        logic [1:0] fs;
        bit         eat;
        int         n;
        int         hx, hy, len;
        bit         tick, hw, hb;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string nm, input bit c, input bit s, input logic [3:0] k,
                       input logic [1:0] f, input bit e, input int n,
                       input int hx, input int hy, input int ln,
                       input bit tk, input bit hw, input bit hb);
        vec_t v;
        v.name = nm; v.clr = c; v.start = s; v.keys_n = k; v.fs = f; v.eat = e; v.n = n;
        v.hx = hx; v.hy = hy; v.len = ln; v.tick = tk; v.hw = hw; v.hb = hb;
        tbl.push_back(v);
    endtask

    task automatic rand_query();
        int r, idx;
        r = int'($urandom_range(3, 0));
        if (r < 2) begin
            idx = int'($urandom_range(mx.size() - 1, 0));
            qx = 6'(mx[idx]);
            qy = 5'(my[idx]);
        end else begin
            qx = 6'($urandom_range(63, 0));
            qy = 5'($urandom_range(31, 0));
        end
    endtask

    localparam logic [3:0] K_NONE  = 4'b1111;
    localparam logic [3:0] K_UP    = 4'b0111;
    localparam logic [3:0] K_DOWN  = 4'b1011;
    localparam logic [3:0] K_LEFT  = 4'b1101;
    localparam logic [3:0] K_DNEAT = 4'b1011;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0; start_s = 1'b0; keys_n = K_NONE; fs = 2'b01; eat = 1'b0;
        qx = 6'd20; qy = 5'd15;
        model_init();

        run_cycle();
        check("rst head_x", 32'(head_x), 32'd20);
        check("rst head_y", 32'(head_y), 32'd15);
        check("rst len", 32'(snake_len), 32'd3);
        check("rst flags", 32'({move_tick, hit_wall, hit_body}), 32'd0);
        rst_n = 1'b1;

        //  name          clr s keys    fs    eat n   hx  hy len tk hw hb
        add("tick1",       0, 1, K_NONE, 2'b01, 0, 4, 21, 15, 3, 1, 0, 0);
        add("tick2",       0, 1, K_NONE, 2'b01, 0, 4, 22, 15, 3, 1, 0, 0);
        add("tick3",       0, 1, K_NONE, 2'b01, 0, 4, 23, 15, 3, 1, 0, 0);
        add("reverse",     0, 1, K_LEFT, 2'b01, 0, 8, 25, 15, 3, 1, 0, 0);
        add("freeze_eat",  0, 0, K_NONE, 2'b01, 1, 1, 25, 15, 3, 0, 0, 0);
        add("grow1",       0, 1, K_NONE, 2'b01, 0, 4, 26, 15, 4, 1, 0, 0);
        add("eat_run",     0, 1, K_NONE, 2'b01, 1, 1, 26, 15, 4, 0, 0, 0);
        add("grow2",       0, 1, K_NONE, 2'b01, 0, 3, 27, 15, 5, 1, 0, 0);
        add("up",          0, 1, K_UP,   2'b01, 0, 4, 27, 14, 5, 1, 0, 0);
        add("left",        0, 1, K_LEFT, 2'b01, 0, 4, 26, 14, 5, 1, 0, 0);
        add("down_hit",    0, 1, K_DOWN, 2'b01, 0, 4, 26, 14, 5, 1, 0, 1);
        add("hit_frozen",  0, 1, K_NONE, 2'b01, 0, 8, 26, 14, 5, 0, 0, 1);
        add("clear1",      1, 0, K_NONE, 2'b01, 0, 1, 20, 15, 3, 0, 0, 0);
        add("to_edge",     0, 1, K_NONE, 2'b10, 0, 38, 39, 15, 3, 1, 0, 0);
        add("wall",        0, 1, K_NONE, 2'b10, 0, 2, 39, 15, 3, 1, 1, 0);
        add("wall_frozen", 0, 1, K_NONE, 2'b10, 0, 4, 39, 15, 3, 0, 1, 0);
        add("clear2",      1, 1, K_UP,   2'b10, 1, 1, 20, 15, 3, 0, 0, 0);
        add("grow_max",    0, 1, K_NONE, 2'b10, 1, 28, 34, 15, 16, 1, 0, 0);
        add("at_max",      0, 1, K_NONE, 2'b10, 1, 2, 35, 15, 16, 1, 0, 0);
        add("clear3",      1, 0, K_NONE, 2'b00, 0, 1, 20, 15, 3, 0, 0, 0);
        add("slow_part",   0, 1, K_NONE, 2'b00, 0, 5, 20, 15, 3, 0, 0, 0);
        add("speed_chg",   0, 1, K_NONE, 2'b01, 0, 1, 21, 15, 3, 1, 0, 0);
        add("clear4",      1, 0, K_NONE, 2'b01, 0, 1, 20, 15, 3, 0, 0, 0);
        add("t_eat",       0, 1, K_NONE, 2'b01, 1, 1, 20, 15, 3, 0, 0, 0);
        add("t_grow",      0, 1, K_NONE, 2'b01, 0, 3, 21, 15, 4, 1, 0, 0);
        add("t_up",        0, 1, K_UP,   2'b01, 0, 4, 21, 14, 4, 1, 0, 0);
        add("t_left",      0, 1, K_LEFT, 2'b01, 0, 4, 20, 14, 4, 1, 0, 0);
        add("tail_free",   0, 1, K_DOWN, 2'b01, 0, 4, 20, 15, 4, 1, 0, 0);
        add("clear5",      1, 0, K_NONE, 2'b01, 0, 1, 20, 15, 3, 0, 0, 0);
        add("u_eat",       0, 1, K_NONE, 2'b01, 1, 1, 20, 15, 3, 0, 0, 0);
        add("u_grow",      0, 1, K_NONE, 2'b01, 0, 3, 21, 15, 4, 1, 0, 0);
        add("u_up",        0, 1, K_UP,   2'b01, 0, 4, 21, 14, 4, 1, 0, 0);
        add("u_left",      0, 1, K_LEFT, 2'b01, 0, 4, 20, 14, 4, 1, 0, 0);
        add("u_down_wait", 0, 1, K_DOWN, 2'b01, 0, 3, 20, 14, 4, 0, 0, 0);
        add("tail_blocks", 0, 1, K_DNEAT, 2'b01, 1, 1, 20, 14, 4, 1, 0, 1);
        add("clear6",      1, 0, K_NONE, 2'b01, 0, 1, 20, 15, 3, 0, 0, 0);

        foreach (tbl[t]) begin
            clr = tbl[t].clr; start_s = tbl[t].start; keys_n = tbl[t].keys_n;
            fs = tbl[t].fs; eat = tbl[t].eat;
            for (int c = 0; c < tbl[t].n; c++) begin
                rand_query();
                run_cycle();
            end
            check({tbl[t].name, " head_x"}, 32'(head_x), 32'(tbl[t].hx));
            check({tbl[t].name, " head_y"}, 32'(head_y), 32'(tbl[t].hy));
            check({tbl[t].name, " len"}, 32'(snake_len), 32'(tbl[t].len));
            check({tbl[t].name, " tick"}, 32'(move_tick), 32'(tbl[t].tick));
            check({tbl[t].name, " hit_wall"}, 32'(hit_wall), 32'(tbl[t].hw));
            check({tbl[t].name, " hit_body"}, 32'(hit_body), 32'(tbl[t].hb));
        end

        clr = 1'b0; eat = 1'b0; keys_n = K_NONE;
        for (int c = 0; c < 6000; c++) begin
            clr     = ($urandom_range(399, 0) == 0) ||
                      ((mhw || mhb) && ($urandom_range(19, 0) == 0));
            start_s = ($urandom_range(15, 0) != 0);
            for (int b = 0; b < 4; b++) keys_n[b] = ($urandom_range(7, 0) != 0);
            if ($urandom_range(49, 0) == 0) fs = 2'($urandom_range(3, 0));
            eat     = ($urandom_range(19, 0) == 0);
            rand_query();
            run_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
